// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle base integer ops plus iterative multiply/divide behind valid/ready.
// Optional macro ALU_SEQ_FAST_SPECIAL_EN: zero-operand multiply, divide-by-zero and signed overflow finish at accept.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_bit0,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
`ifdef ALU_SEQ_FAST_SPECIAL_EN
  localparam bit FAST_SPECIAL = 1'b1;
`else
  localparam bit FAST_SPECIAL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic [4:0]           op_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q;
  logic                 neg_q, neg_rem_q, spec_q;
  logic [WIDTH-1:0]     spec_res_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     out_q;
  logic                 out_valid_q, busy_q;

  logic                 accept_s, is_mul_s, is_div_s, is_multi_s;
  logic                 lhs_sgn_s, rhs_sgn_s, sa_s, sb_s, spec_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s, spec_res_s, opnd_init_s;
  logic [2*WIDTH-1:0]   acc_init_s, prod_s;
  logic [WIDTH:0]       mul_sum_s, div_cand_s, div_diff_s;
  logic [WIDTH-1:0]     quo_s, rem_s, final_s;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [4:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
    case (o)
      5'd1:    alu_fn = a + b;
      5'd2:    alu_fn = a - b;
      5'd3:    alu_fn = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd4:    alu_fn = {{(WIDTH-1){1'b0}}, (a < b)};
      5'd5:    alu_fn = a ^ b;
      5'd6:    alu_fn = a | b;
      5'd7:    alu_fn = a & b;
      5'd8:    alu_fn = a << sh;
      5'd9:    alu_fn = a >> sh;
      5'd10:   alu_fn = $signed(a) >>> sh;
      5'd11:   alu_fn = {{(WIDTH-1){1'b0}}, (a == b)};
      default: alu_fn = '0;
    endcase
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_bit0  = out_q[0];
  assign busy      = busy_q;

  // Decode a new op: operand magnitudes, sign flags and architected special-case results.
  always_comb begin
    is_mul_s   = (op >= 5'd12) && (op <= 5'd15);
    is_div_s   = (op >= 5'd16) && (op <= 5'd19);
    is_multi_s = is_mul_s || is_div_s;
    lhs_sgn_s  = (op == 5'd13) || (op == 5'd14) || (op == 5'd16) || (op == 5'd18);
    rhs_sgn_s  = (op == 5'd13) || (op == 5'd16) || (op == 5'd18);
    sa_s       = lhs_sgn_s && lhs[WIDTH-1];
    sb_s       = rhs_sgn_s && rhs[WIDTH-1];
    a_mag_s    = sa_s ? -lhs : lhs;
    b_mag_s    = sb_s ? -rhs : rhs;
    spec_s     = 1'b0;
    spec_res_s = '0;
    if (is_mul_s) begin
      spec_s = (lhs == '0) || (rhs == '0);
    end else if (is_div_s) begin
      // op[1] selects remainder, op[0] selects unsigned
      if (rhs == '0) begin
        spec_s     = 1'b1;
        spec_res_s = op[1] ? lhs : ONES;
      end else if (!op[0] && (lhs == MIN_VAL) && (rhs == ONES)) begin
        spec_s     = 1'b1;
        spec_res_s = op[1] ? '0 : lhs;
      end else begin
        spec_s = 1'b0;
      end
    end else begin
      spec_s = 1'b0;
    end
    acc_init_s  = is_div_s ? {{WIDTH{1'b0}}, a_mag_s} : {{WIDTH{1'b0}}, b_mag_s};
    opnd_init_s = is_div_s ? b_mag_s : a_mag_s;
  end

  // One shift-add or restoring-divide step, plus the sign-corrected result of the last step.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_cand_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s = div_cand_s - {1'b0, opnd_q};
    if (op_q[4]) begin
      acc_d = div_diff_s[WIDTH] ? {div_cand_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
    prod_s = neg_q ? -acc_d : acc_d;
    quo_s  = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem_s  = neg_rem_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    if (spec_q) begin
      final_s = spec_res_q;
    end else begin
      case (op_q)
        5'd12:                final_s = prod_s[WIDTH-1:0];
        5'd13, 5'd14, 5'd15:  final_s = prod_s[2*WIDTH-1:WIDTH];
        5'd16, 5'd17:         final_s = quo_s;
        5'd18, 5'd19:         final_s = rem_s;
        default:              final_s = '0;
      endcase
    end
  end

  // Control FSM with registered result, valid and busy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      op_q        <= 5'd0;
      acc_q       <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
    end else if (accept_s) begin
      op_q       <= op;
      acc_q      <= acc_init_s;
      opnd_q     <= opnd_init_s;
      neg_q      <= sa_s ^ sb_s;
      neg_rem_q  <= sa_s;
      spec_q     <= spec_s;
      spec_res_q <= spec_res_s;
      cnt_q      <= '0;
      if (is_multi_s && !(FAST_SPECIAL && spec_s)) begin
        state_q     <= BUSY;
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= DONE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b1;
        out_q       <= is_multi_s ? spec_res_s : alu_fn(op, lhs, rhs);
      end
    end else begin
      case (state_q)
        BUSY: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_q       <= final_s;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard of modelled results plus directed latency/handshake checks.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [4:0]  op = 5'd1;
  logic [31:0] lhs = 32'd0;
  logic [31:0] rhs = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        out_bit0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

`ifdef ALU_SEQ_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .lhs(lhs), .rhs(rhs), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_bit0(out_bit0), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint pa, pb, p;
    logic [63:0] up;
    logic ovf;
    sa = a; sb = b;
    ovf = (a == MIN32) && (b == 32'hFFFF_FFFF);
    p = 64'sd0; up = 64'd0;
    case (o)
      5'd1:  model = a + b;
      5'd2:  model = a - b;
      5'd3:  model = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  model = (a < b) ? 32'd1 : 32'd0;
      5'd5:  model = a ^ b;
      5'd6:  model = a | b;
      5'd7:  model = a & b;
      5'd8:  model = a << b[4:0];
      5'd9:  model = a >> b[4:0];
      5'd10: model = sa >>> b[4:0];
      5'd11: model = (a == b) ? 32'd1 : 32'd0;
      5'd12: begin up = {32'd0, a} * {32'd0, b}; model = up[31:0]; end
      5'd13: begin pa = sa; pb = sb; p = pa * pb; model = p[63:32]; end
      5'd14: begin pa = sa; pb = {32'd0, b}; p = pa * pb; model = p[63:32]; end
      5'd15: begin up = {32'd0, a} * {32'd0, b}; model = up[63:32]; end
      5'd16: model = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      5'd17: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd18: model = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      5'd19: model = (b == 32'd0) ? a : a % b;
      default: model = 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic special;
    if (o < 5'd12 || o > 5'd19) return 1;
    if (o <= 5'd15) special = (a == 32'd0) || (b == 32'd0);
    else special = (b == 32'd0) || (((o == 5'd16) || (o == 5'd18)) && (a == MIN32) && (b == 32'hFFFF_FFFF));
    return special ? SPEC_LAT : 33;
  endfunction

  // Scoreboard: pop on each output transfer, push on each accept, cleared by reset/flush.
  always @(negedge clk) begin : sb_mon
    logic [31:0] e;
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("sb_out", out, e);
          check("sb_bit0", 32'(out_bit0), 32'(e[0]));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(op, lhs, rhs));
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_val, input int lat_exp, input int busy_exp, input string tag);
    int w, lat, bcnt;
    op = o; lhs = a; rhs = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom_range(0, 19)); lhs = $urandom; rhs = $urandom;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_val"}, out, exp_val);
    if (busy_exp >= 0) check({tag, "_busy"}, 32'(bcnt), 32'(busy_exp));
  endtask

  initial begin
    logic [4:0]  o;
    logic [31:0] a, b;
    int seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    issue(5'd1,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, -1, "add_ovf");
    issue(5'd10, 32'h8000_0000, 32'd4,         32'hF800_0000, 1, -1, "sra");
    issue(5'd4,  32'd1,         32'hFFFF_FFFF, 32'd1,         1, -1, "sltu");
    issue(5'd3,  32'd1,         32'hFFFF_FFFF, 32'd0,         1, -1, "slt");
    issue(5'd8,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1, -1, "sll");
    issue(5'd11, 32'h1234_5678, 32'h1234_5678, 32'd1,         1, -1, "seq");
    issue(5'd25, 32'hDEAD_BEEF, 32'h1,         32'd0,         1, -1, "rsvd");

    for (int i = 0; i < 8; i++) begin
      op = 5'($urandom_range(0, 11)); lhs = $urandom; rhs = $urandom; in_valid = 1'b1;
      check("b2b_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("b2b_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    issue(5'd13, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32, "mulh");
    issue(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32, "mulhu");
    issue(5'd12, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 33, 32, "mul");
    issue(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32, "mulhsu");
    issue(5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 32, "div");
    issue(5'd18, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 32, "rem");
    issue(5'd17, 32'd5,         32'd0,         32'hFFFF_FFFF, SPEC_LAT, -1, "divu0");
    issue(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_LAT, -1, "rem_ovf");
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, -1, "div_ovf");
    issue(5'd19, 32'h0000_0123, 32'd0,         32'h0000_0123, SPEC_LAT, -1, "remu0");
    issue(5'd13, 32'd0,         32'h8000_0000, 32'd0,         SPEC_LAT, -1, "mul0");

    // Backpressure: result must hold while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(5'd1, 32'h10, 32'h20, 32'h30, 1, -1, "bp_add");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_out", out, 32'h30);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    op = 5'd2; lhs = 32'd10; rhs = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_valid", 32'(out_valid), 32'd1);
    check("bp_new_out", out, 32'd7);
    @(posedge clk); #1;

    // Flush in the middle of a divide: nothing may come out.
    op = 5'd16; lhs = 32'd1000; rhs = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("fl_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("fl_quiet", 32'(seen), 32'd0);
    issue(5'd1, 32'd3, 32'd4, 32'd7, 1, -1, "fl_add");

    for (int i = 0; i < 24; i++) begin
      o = 5'($urandom_range(0, 31)); a = $urandom; b = $urandom;
      if (i % 6 == 0) b = 32'd0;
      if (i % 8 == 3) b = b & 32'h0000_00FF;
      issue(o, a, b, model(o, a, b), exp_lat(o, a, b), -1, "rnd");
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
